// File: rtl/button_event_gen.sv
// Turns a debounced switch level into single-cycle press/release/long-press/repeat
// events, plus a held level and a wrapping press counter.
//
// state | meaning
// IDLE  | released, waiting for a 0->1 edge
// SHORT | pressed, counting towards the long-press threshold
// LONG  | long-held, counting repeat intervals while repeat is enabled
module button_event_gen #(
    parameter int unsigned c_LONG_PRESS_CYCLES = 12500000,
    parameter int unsigned c_REPEAT_CYCLES     = 2500000,
    parameter int unsigned c_CNT_WIDTH         = 24
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch,
    input  logic       i_Repeat_En,
    output logic       o_Press,
    output logic       o_Release,
    output logic       o_Long_Press,
    output logic       o_Repeat,
    output logic       o_Held,
    output logic [7:0] o_Press_Count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2
    } state_t;

    localparam logic [c_CNT_WIDTH-1:0] LONG_LAST = c_CNT_WIDTH'(c_LONG_PRESS_CYCLES - 1);
    localparam logic [c_CNT_WIDTH-1:0] REP_LAST  = c_CNT_WIDTH'(c_REPEAT_CYCLES - 1);
    localparam logic [c_CNT_WIDTH-1:0] CNT_ONE   = c_CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   prev_q;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    logic                   held_q, held_d;
    logic [7:0]             count_q, count_d;
    logic                   rise;

    // prev_q resets high so a switch held through reset never counts as a press
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= i_Switch;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
            count_q   <= count_d;
        end
    end

    assign rise = i_Switch & ~prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        held_d    = held_q;
        count_d   = count_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_SHORT;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            ST_SHORT: begin
                // Release is tested first so it wins over a coincident threshold
                if (!i_Switch) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LONG: begin
                if (!i_Switch) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else if (!i_Repeat_En) begin
                    cnt_d = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign o_Press       = press_q;
    assign o_Release     = release_q;
    assign o_Long_Press  = long_q;
    assign o_Repeat      = repeat_q;
    assign o_Held        = held_q;
    assign o_Press_Count = count_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with long=10, repeat=4, counter width 8.
module tb_button_event_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b0;
    logic       en  = 1'b0;
    logic       o_press, o_release, o_long, o_repeat, o_held;
    logic [7:0] o_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int n_press, n_rel, n_long, n_rep;
    int t_press, t_rel, t_long;
    int t_rep[$];

    typedef struct {
        logic       sw, en, rst;
        logic       press, rel, lng, rep, held;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    button_event_gen #(
        .c_LONG_PRESS_CYCLES(10),
        .c_REPEAT_CYCLES    (4),
        .c_CNT_WIDTH        (8)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Switch     (sw),
        .i_Repeat_En  (en),
        .o_Press      (o_press),
        .o_Release    (o_release),
        .o_Long_Press (o_long),
        .o_Repeat     (o_repeat),
        .o_Held       (o_held),
        .o_Press_Count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
        t_press = -1; t_rel = -1; t_long = -1;
        t_rep.delete();
    endtask

    // Drive one cycle of inputs, then observe the registered response 1 ns after the edge
    task automatic step(input logic s, input logic e, input logic r);
        sw  = s;
        en  = e;
        rst = r;
        @(posedge clk);
        #1;
        cyc++;
        if (o_press)   begin n_press++; t_press = cyc; end
        if (o_release) begin n_rel++;   t_rel   = cyc; end
        if (o_long)    begin n_long++;  t_long  = cyc; end
        if (o_repeat)  begin n_rep++;   t_rep.push_back(cyc); end
        check("onehot", 32'($countones({o_press, o_release, o_long, o_repeat}) <= 1), 32'd1);
    endtask

    function automatic void add(input logic s, input logic e, input logic r,
                                input logic p, input logic rl, input logic l,
                                input logic rp, input logic h, input logic [7:0] c);
        vec_t v;
        v.sw = s; v.en = e; v.rst = r;
        v.press = p; v.rel = rl; v.lng = l; v.rep = rp; v.held = h; v.cnt = c;
        tbl.push_back(v);
    endfunction

    initial begin
        clear_stats();

        // held through reset: no press
        add(1,0,1, 0,0,0,0,0, 8'd0);
        add(1,0,0, 0,0,0,0,0, 8'd0);
        for (int i = 0; i < 5; i++) add(0,0,0, 0,0,0,0,0, 8'd0);
        // 3-cycle press
        add(1,0,0, 1,0,0,0,1, 8'd1);
        add(1,0,0, 0,0,0,0,1, 8'd1);
        add(1,0,0, 0,0,0,0,1, 8'd1);
        add(0,0,0, 0,1,0,0,0, 8'd1);
        add(0,0,0, 0,0,0,0,0, 8'd1);
        // release lands on the long threshold cycle
        add(1,0,0, 1,0,0,0,1, 8'd2);
        for (int i = 0; i < 9; i++) add(1,0,0, 0,0,0,0,1, 8'd2);
        add(0,0,0, 0,1,0,0,0, 8'd2);
        add(0,0,0, 0,0,0,0,0, 8'd2);
        // one cycle longer reaches the long press
        add(1,0,0, 1,0,0,0,1, 8'd3);
        for (int i = 0; i < 9; i++) add(1,0,0, 0,0,0,0,1, 8'd3);
        add(1,0,0, 0,0,1,0,1, 8'd3);
        add(1,0,0, 0,0,0,0,1, 8'd3);
        add(0,0,0, 0,1,0,0,0, 8'd3);
        // single-cycle press
        add(0,0,0, 0,0,0,0,0, 8'd3);
        add(1,0,0, 1,0,0,0,1, 8'd4);
        add(0,0,0, 0,1,0,0,0, 8'd4);
        add(0,0,0, 0,0,0,0,0, 8'd4);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sw, tbl[i].en, tbl[i].rst);
            check($sformatf("vec[%0d]", i),
                  32'({o_press, o_release, o_long, o_repeat, o_held, o_count}),
                  32'({tbl[i].press, tbl[i].rel, tbl[i].lng, tbl[i].rep, tbl[i].held, tbl[i].cnt}));
        end

        // hold 20 cycles, repeat disabled
        step(0,0,1); step(0,0,0); step(0,0,0);
        clear_stats();
        for (int i = 0; i < 20; i++) step(1,0,0);
        for (int i = 0; i < 3; i++) step(0,0,0);
        check("t2_press_n", n_press, 1);
        check("t2_long_n", n_long, 1);
        check("t2_long_ofs", t_long - t_press, 10);
        check("t2_rep_n", n_rep, 0);
        check("t2_rel_n", n_rel, 1);
        check("t2_count", o_count, 1);

        // hold 25 cycles, repeat enabled
        step(0,0,1); step(0,0,0); step(0,0,0);
        clear_stats();
        for (int i = 0; i < 25; i++) step(1,1,0);
        for (int i = 0; i < 3; i++) step(0,1,0);
        check("t3_long_ofs", t_long - t_press, 10);
        check("t3_rep_n", n_rep, 3);
        if (t_rep.size() == 3) begin
            check("t3_rep0", t_rep[0] - t_press, 14);
            check("t3_rep1", t_rep[1] - t_press, 18);
            check("t3_rep2", t_rep[2] - t_press, 22);
        end
        check("t3_rel_ofs", t_rel - t_press, 25);
        check("t3_rel_n", n_rel, 1);

        // release collides with the fourth repeat
        step(0,0,1); step(0,0,0); step(0,0,0);
        clear_stats();
        for (int i = 0; i < 26; i++) step(1,1,0);
        for (int i = 0; i < 3; i++) step(0,1,0);
        check("t3c_rep_n", n_rep, 3);
        check("t3c_rel_ofs", t_rel - t_press, 26);
        check("t3c_rel_n", n_rel, 1);

        // repeat enabled only after the long press restarts a full interval
        step(0,0,1); step(0,0,0); step(0,0,0);
        clear_stats();
        for (int i = 0; i < 15; i++) step(1,0,0);
        for (int i = 0; i < 6; i++) step(1,1,0);
        step(0,0,0);
        check("reen_long_ofs", t_long - t_press, 10);
        check("reen_rep_n", n_rep, 1);
        if (t_rep.size() == 1) check("reen_rep_ofs", t_rep[0] - t_press, 18);

        // reset mid-LONG with the switch held
        step(0,0,1); step(0,0,0);
        for (int i = 0; i < 15; i++) step(1,0,0);
        check("t5_pre_held", o_held, 1);
        clear_stats();
        step(1,0,1);
        check("t5_rst_outs", 32'({o_press, o_release, o_long, o_repeat, o_held, o_count}), 32'd0);
        step(1,0,1); step(1,0,1);
        for (int i = 0; i < 10; i++) step(1,0,0);
        check("t5_no_press", n_press, 0);
        check("t5_no_rel", n_rel, 0);
        check("t5_held", o_held, 0);
        step(0,0,0);
        step(1,0,0);
        check("t5_press", o_press, 1);
        check("t5_count", o_count, 1);
        step(0,0,0); step(0,0,0);

        // 257 short presses wrap the counter
        step(0,0,1); step(0,0,0);
        clear_stats();
        for (int i = 0; i < 257; i++) begin
            step(1,0,0);
            if (i == 255) check("t6_wrap0", o_count, 0);
            if (i == 256) check("t6_wrap1", o_count, 1);
            step(1,0,0);
            step(0,0,0);
            step(0,0,0);
        end
        check("t6_press_n", n_press, 257);
        check("t6_rel_n", n_rel, 257);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Consumes a debounced active-high switch level and converts it into single-cycle event pulses: press, release, long-press and auto-repeat. It also provides a held level and a press counter. It sits directly downstream of the switch debouncer and feeds game/UI logic (paddle control, menu stepping) on the 25 MHz Go Board clock.

Parameters:
c_LONG_PRESS_CYCLES, 12500000, cycles of continuous hold from o_Press to o_Long_Press (0.5 s at 25 MHz); legal range 2 .. 2^c_CNT_WIDTH-1
c_REPEAT_CYCLES, 2500000, cycles between o_Repeat pulses once long-held (100 ms at 25 MHz); legal range 2 .. 2^c_CNT_WIDTH-1
c_CNT_WIDTH, 24, width of the internal hold/repeat counter

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_Switch  in  1  debounced switch level, 1 = pressed
i_Repeat_En  in  1  enables auto-repeat while long-held; sampled every cycle
o_Press  out  1  one-cycle pulse on press
o_Release  out  1  one-cycle pulse on release
o_Long_Press  out  1  one-cycle pulse when hold reaches c_LONG_PRESS_CYCLES
o_Repeat  out  1  one-cycle pulse every c_REPEAT_CYCLES while long-held and enabled
o_Held  out  1  level, 1 while in a pressed state (SHORT or LONG)
o_Press_Count  out  8  number of presses since reset, wraps 255 -> 0

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, counter 0, edge register r_Prev = 1.
- r_Prev <= i_Switch every non-reset cycle. Rising edge = i_Switch & ~r_Prev.
- r_Prev = 1 at reset, so a switch held through reset deassertion generates no press. It must read 0, then 1.
- States: IDLE, SHORT, LONG.
- IDLE, on rising edge: go to SHORT, clear counter, pulse o_Press, increment o_Press_Count, set o_Held. Latency: o_Press is high the cycle after the first cycle i_Switch = 1.
- SHORT, i_Switch = 0: pulse o_Release, clear o_Held and counter, go to IDLE.
- SHORT, i_Switch = 1: increment counter. When counter = c_LONG_PRESS_CYCLES-1, pulse o_Long_Press, clear counter, go to LONG. o_Long_Press is therefore exactly c_LONG_PRESS_CYCLES cycles after o_Press.
- LONG, i_Switch = 0: pulse o_Release, clear o_Held and counter, go to IDLE.
- LONG, i_Switch = 1 and i_Repeat_En = 1: increment counter. At c_REPEAT_CYCLES-1, pulse o_Repeat and clear counter. The first o_Repeat is c_REPEAT_CYCLES cycles after o_Long_Press, then periodic.
- LONG, i_Repeat_En = 0: counter held at 0, no o_Repeat. Re-enabling restarts a full c_REPEAT_CYCLES interval.
- Release-vs-threshold collision: if the first 0 sample occurs in the cycle that would fire o_Long_Press or o_Repeat, release wins. Only o_Release pulses; no long/repeat pulse.
- At most one of o_Press / o_Release / o_Long_Press / o_Repeat is high in any cycle. Pulses never exceed one cycle.
- A press/release shorter than one cycle cannot occur, because the input is debounced. Any 1-cycle high still yields o_Press followed by o_Release on the next cycle.
- o_Press_Count wraps modulo 256 with no saturation or flag.
- Reset mid-hold: the next cycle shows all outputs 0 and no o_Release. The button must be released and re-pressed to produce o_Press.
- Counter never exceeds max(c_LONG_PRESS_CYCLES, c_REPEAT_CYCLES)-1; no overflow is possible within the legal parameter range.

Test Plan:
(Bench parameters: c_LONG_PRESS_CYCLES=10, c_REPEAT_CYCLES=4, c_CNT_WIDTH=8.)
1. Reset, i_Switch 0 for 5 cycles, then 1 for 3 cycles, then 0 -> o_Press once (1 cycle after rise), o_Release once (1 cycle after fall), no o_Long_Press, o_Held high 3 cycles, o_Press_Count=1.
2. Hold 1 for 20 cycles, i_Repeat_En=0 -> o_Long_Press exactly 10 cycles after o_Press, zero o_Repeat, one o_Release, o_Press_Count=1.
3. Hold 1 for 25 cycles, i_Repeat_En=1 -> o_Long_Press at +10; o_Repeat at +14, +18, +22, +26 relative to o_Press, with the last suppressed if release collides; o_Release on release.
4. Release timed so the first 0 sample lands on the long-threshold cycle -> o_Release only, no o_Long_Press; state returns to IDLE.
5. Hold i_Switch=1 while asserting i_Reset for 3 cycles mid-LONG, keep it 1 for 10 more cycles -> all outputs 0, no o_Press. Then drop to 0 and raise -> o_Press, o_Press_Count=1.
6. 257 short presses (2 cycles high, 2 low) -> o_Press_Count reads 0 after the 256th press and 1 after the 257th; exactly 257 o_Press and 257 o_Release pulses.
